// File: rtl/unit_clause_scanner_if.sv
// Unit-literal hand-off stream from the clause scanner to the BCP/assignment controller.
// The scanner drives valid/literal/index; the consumer drives ready.
interface unit_clause_scanner_if #(
    parameter int WIDTH = 9,
    parameter int IDX_W = 4
);
    logic             unit_valid;
    logic             unit_ready;
    logic [WIDTH-1:0] unit_literal;
    logic [IDX_W-1:0] unit_index;

    modport master (
        output unit_valid,
        output unit_literal,
        output unit_index,
        input  unit_ready
    );

    modport slave (
        input  unit_valid,
        input  unit_literal,
        input  unit_index,
        output unit_ready
    );
endinterface

// File: rtl/unit_clause_scanner.sv
// Sequential unit-clause scanner: walks the clause bank one clause per cycle, streams every
// unit literal over a valid/ready handshake and stops on the first conflicting clause.
module unit_clause_scanner #(
    parameter int WIDTH       = 9,
    parameter int K           = 3,
    parameter int NUM_CLAUSES = 16,
    parameter int IDX_W       = $clog2(NUM_CLAUSES),
    parameter int CNT_W       = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [NUM_CLAUSES*K*WIDTH-1:0] cnf_packed,
    input  logic [NUM_CLAUSES-1:0]         clause_active,
    input  logic [NUM_CLAUSES*K-1:0]       lit_open,
    unit_clause_scanner_if.master          unit_bus,
    output logic                           busy,
    output logic                           done,
    output logic                           conflict,
    output logic [IDX_W-1:0]               conflict_index,
    output logic [CNT_W-1:0]               unit_count
);

    localparam int CLW  = K * WIDTH;
    localparam int OC_W = $clog2(K + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLAUSES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic logic [OC_W-1:0] popcount(input logic [K-1:0] bits);
        logic [OC_W-1:0] cnt;
        cnt = {OC_W{1'b0}};
        for (int j = 0; j < K; j++) begin
            cnt = cnt + OC_W'(bits[j]);
        end
        return cnt;
    endfunction

    // For a unit clause exactly one bit is set, so the last match is the only match.
    function automatic logic [WIDTH-1:0] pick_open(input logic [CLW-1:0] lits,
                                                   input logic [K-1:0]   open_bits);
        logic [WIDTH-1:0] sel;
        sel = {WIDTH{1'b0}};
        for (int j = 0; j < K; j++) begin
            sel = open_bits[j] ? lits[j*WIDTH +: WIDTH] : sel;
        end
        return sel;
    endfunction

    state_t           state_r, state_s;
    logic [IDX_W-1:0] idx_r, idx_s;
    logic             unit_valid_r, unit_valid_s;
    logic [WIDTH-1:0] unit_literal_r, unit_literal_s;
    logic [IDX_W-1:0] unit_index_r, unit_index_s;
    logic             busy_r, busy_s;
    logic             done_r, done_s;
    logic             conflict_r, conflict_s;
    logic [IDX_W-1:0] conflict_index_r, conflict_index_s;
    logic [CNT_W-1:0] unit_count_r, unit_count_s;

    logic [CLW-1:0]   cur_lits_s;
    logic [K-1:0]     cur_open_s;
    logic             cur_active_s;
    logic [OC_W-1:0]  open_cnt_s;
    logic             is_unit_s;
    logic             is_confl_s;
    logic [WIDTH-1:0] open_lit_s;
    logic             handshake_s;

    // Select and classify the clause currently pointed at by idx_r.
    always_comb begin
        cur_lits_s   = {CLW{1'b0}};
        cur_open_s   = {K{1'b0}};
        cur_active_s = 1'b0;
        for (int c = 0; c < NUM_CLAUSES; c++) begin
            cur_lits_s   = (idx_r == IDX_W'(c)) ? cnf_packed[c*CLW +: CLW] : cur_lits_s;
            cur_open_s   = (idx_r == IDX_W'(c)) ? lit_open[c*K +: K]      : cur_open_s;
            cur_active_s = (idx_r == IDX_W'(c)) ? clause_active[c]        : cur_active_s;
        end
        open_cnt_s  = popcount(cur_open_s);
        is_unit_s   = cur_active_s && (open_cnt_s == OC_W'(1));
        is_confl_s  = cur_active_s && (open_cnt_s == {OC_W{1'b0}});
        open_lit_s  = pick_open(cur_lits_s, cur_open_s);
        handshake_s = unit_valid_r && unit_bus.unit_ready;
    end

    // Next-state and next-output logic for the scan controller.
    always_comb begin
        state_s          = state_r;
        idx_s            = idx_r;
        unit_valid_s     = unit_valid_r;
        unit_literal_s   = unit_literal_r;
        unit_index_s     = unit_index_r;
        conflict_s       = conflict_r;
        conflict_index_s = conflict_index_r;
        unit_count_s     = unit_count_r;

        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s          = SCAN;
                    idx_s            = {IDX_W{1'b0}};
                    conflict_s       = 1'b0;
                    conflict_index_s = {IDX_W{1'b0}};
                    unit_count_s     = {CNT_W{1'b0}};
                end else begin
                    state_s = IDLE;
                end
            end
            SCAN: begin
                if (is_confl_s) begin
                    conflict_s       = 1'b1;
                    conflict_index_s = idx_r;
                    state_s          = DONE;
                end else if (is_unit_s) begin
                    unit_literal_s = open_lit_s;
                    unit_index_s   = idx_r;
                    unit_valid_s   = 1'b1;
                    state_s        = HOLD;
                end else if (idx_r == LAST_IDX) begin
                    state_s = DONE;
                end else begin
                    idx_s = idx_r + IDX_W'(1);
                end
            end
            HOLD: begin
                if (handshake_s) begin
                    unit_valid_s = 1'b0;
                    unit_count_s = (unit_count_r == CNT_MAX) ? unit_count_r
                                                             : unit_count_r + CNT_W'(1);
                    if (idx_r == LAST_IDX) begin
                        state_s = DONE;
                    end else begin
                        idx_s   = idx_r + IDX_W'(1);
                        state_s = SCAN;
                    end
                end else begin
                    state_s = HOLD;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        busy_s = (state_s == SCAN) || (state_s == HOLD);
        done_s = (state_s == DONE);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r          <= IDLE;
            idx_r            <= {IDX_W{1'b0}};
            unit_valid_r     <= 1'b0;
            unit_literal_r   <= {WIDTH{1'b0}};
            unit_index_r     <= {IDX_W{1'b0}};
            busy_r           <= 1'b0;
            done_r           <= 1'b0;
            conflict_r       <= 1'b0;
            conflict_index_r <= {IDX_W{1'b0}};
            unit_count_r     <= {CNT_W{1'b0}};
        end else begin
            state_r          <= state_s;
            idx_r            <= idx_s;
            unit_valid_r     <= unit_valid_s;
            unit_literal_r   <= unit_literal_s;
            unit_index_r     <= unit_index_s;
            busy_r           <= busy_s;
            done_r           <= done_s;
            conflict_r       <= conflict_s;
            conflict_index_r <= conflict_index_s;
            unit_count_r     <= unit_count_s;
        end
    end

    assign unit_bus.unit_valid   = unit_valid_r;
    assign unit_bus.unit_literal = unit_literal_r;
    assign unit_bus.unit_index   = unit_index_r;
    assign busy                  = busy_r;
    assign done                  = done_r;
    assign conflict              = conflict_r;
    assign conflict_index        = conflict_index_r;
    assign unit_count            = unit_count_r;

endmodule

// File: tb/tb_unit_clause_scanner.sv
// Scoreboard bench for unit_clause_scanner: a clause-level reference model queues expected
// units and scan results; a negedge monitor pops and compares whenever the DUT presents them.
module tb_unit_clause_scanner;
    localparam int WIDTH   = 9;
    localparam int K       = 3;
    localparam int NC      = 16;
    localparam int IDX_W   = 4;
    localparam int CNT_W   = 2;
    localparam int CNT_MAX = 3;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  start;
    logic [NC*K*WIDTH-1:0] cnf_packed;
    logic [NC-1:0]         clause_active;
    logic [NC*K-1:0]       lit_open;
    logic                  busy, done, conflict;
    logic [IDX_W-1:0]      conflict_index;
    logic [CNT_W-1:0]      unit_count;

    unit_clause_scanner_if #(.WIDTH(WIDTH), .IDX_W(IDX_W)) ub ();

    unit_clause_scanner #(
        .WIDTH(WIDTH), .K(K), .NUM_CLAUSES(NC), .IDX_W(IDX_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .cnf_packed(cnf_packed), .clause_active(clause_active), .lit_open(lit_open),
        .unit_bus(ub.master),
        .busy(busy), .done(done), .conflict(conflict),
        .conflict_index(conflict_index), .unit_count(unit_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int ready_mode = 0;   // 0: ready tied 1, 1: random ready, 2: ready held 0

    always @(posedge clk) cyc <= cyc + 1;

    logic [WIDTH-1:0] lits [NC][K];
    logic             act  [NC];
    logic [K-1:0]     opn  [NC];

    typedef struct { int idx; logic [WIDTH-1:0] lit; } unit_t;
    typedef struct { logic confl; int cidx; int cnt; } res_t;
    unit_t unit_q[$];
    res_t  res_q[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference model: straight walk of the clause list from the rules.
    task automatic model_and_push(output int lat);
        int units, scanned, ci, nopen;
        logic cf;
        units = 0; scanned = NC; ci = 0; cf = 1'b0;
        for (int c = 0; c < NC; c++) begin
            if (act[c]) begin
                nopen = $countones(opn[c]);
                if (nopen == 0) begin
                    cf = 1'b1; ci = c; scanned = c + 1;
                    break;
                end
                if (nopen == 1) begin
                    for (int j = 0; j < K; j++)
                        if (opn[c][j]) unit_q.push_back('{idx: c, lit: lits[c][j]});
                    units++;
                end
            end
        end
        res_q.push_back('{confl: cf, cidx: ci, cnt: (units > CNT_MAX) ? CNT_MAX : units});
        lat = scanned + units;
    endtask

    task automatic drive_inputs();
        for (int c = 0; c < NC; c++) begin
            clause_active[c]  = act[c];
            lit_open[c*K +: K] = opn[c];
            for (int j = 0; j < K; j++)
                cnf_packed[(c*K+j)*WIDTH +: WIDTH] = lits[c][j];
        end
    endtask

    task automatic clear_bank();
        for (int c = 0; c < NC; c++) begin
            act[c] = 1'b0;
            opn[c] = 3'b111;
            for (int j = 0; j < K; j++) lits[c][j] = WIDTH'($urandom_range(0, 511));
        end
    endtask

    task automatic gen_random(input int p_unit, input int p_confl);
        int r;
        logic [K-1:0] v;
        for (int c = 0; c < NC; c++) begin
            act[c] = ($urandom_range(0, 99) < 70);
            r = $urandom_range(0, 99);
            if (r < p_confl) opn[c] = 3'b000;
            else if (r < p_confl + p_unit) opn[c] = 3'b001 << $urandom_range(0, K-1);
            else begin
                v = 3'b000;
                while ($countones(v) < 2) v = K'($urandom_range(0, 7));
                opn[c] = v;
            end
            for (int j = 0; j < K; j++) lits[c][j] = WIDTH'($urandom_range(0, 511));
        end
    endtask

    // Issue one scan, wait for done (bounded) and optionally check the latency.
    task automatic run_scan(input bit check_lat);
        int lat, start_cyc;
        bit got_done;
        drive_inputs();
        model_and_push(lat);
        @(negedge clk);
        start = 1'b1;
        start_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        got_done = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (done) begin got_done = 1'b1; break; end
            @(negedge clk);
        end
        if (!got_done) begin
            total++; bad++;
            $display("FAIL scan_timeout: no done within 3000 cycles");
            unit_q.delete(); res_q.delete();
        end else begin
            if (check_lat) chk("done_latency", 32'(cyc - start_cyc), 32'(lat + 1));
            chk("units_drained", 32'(unit_q.size()), 32'd0);
        end
        @(negedge clk);
    endtask

    // Ready driver, updated just after each rising edge.
    initial begin
        ub.unit_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       ub.unit_ready = 1'b1;
                1:       ub.unit_ready = ($urandom_range(0, 2) != 0);
                default: ub.unit_ready = 1'b0;
            endcase
        end
    end

    // Monitor: compare presented units and scan results against the scoreboard queues.
    initial begin
        logic prev_valid, prev_done;
        logic [WIDTH-1:0] prev_lit;
        logic [IDX_W-1:0] prev_idx;
        unit_t eu;
        res_t  er;
        prev_valid = 1'b0; prev_done = 1'b0; prev_lit = '0; prev_idx = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (ub.unit_valid && !prev_valid) begin
                    if (unit_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_unit: got index %0d literal %0h expected none",
                                 ub.unit_index, ub.unit_literal);
                    end else begin
                        eu = unit_q.pop_front();
                        chk("unit_index", 32'(ub.unit_index), 32'(eu.idx));
                        chk("unit_literal", 32'(ub.unit_literal), 32'(eu.lit));
                    end
                end else if (ub.unit_valid && prev_valid) begin
                    chk("stall_index_stable", 32'(ub.unit_index), 32'(prev_idx));
                    chk("stall_literal_stable", 32'(ub.unit_literal), 32'(prev_lit));
                end
                if (done) begin
                    if (prev_done) begin
                        total++; bad++;
                        $display("FAIL done_width: got 2+ cycles expected 1");
                    end
                    if (res_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_done: got done expected none");
                    end else begin
                        er = res_q.pop_front();
                        chk("conflict", {31'd0, conflict}, {31'd0, er.confl});
                        chk("conflict_index", 32'(conflict_index), 32'(er.cidx));
                        chk("unit_count", 32'(unit_count), 32'(er.cnt));
                        chk("busy_at_done", {31'd0, busy}, 32'd0);
                    end
                end
            end
            prev_valid = ub.unit_valid && !rst;
            prev_done  = done && !rst;
            prev_lit   = ub.unit_literal;
            prev_idx   = ub.unit_index;
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_unit_valid"},   {31'd0, ub.unit_valid}, 32'd0);
        chk({tag, "_unit_literal"}, 32'(ub.unit_literal), 32'd0);
        chk({tag, "_unit_index"},   32'(ub.unit_index), 32'd0);
        chk({tag, "_busy"},         {31'd0, busy}, 32'd0);
        chk({tag, "_done"},         {31'd0, done}, 32'd0);
        chk({tag, "_conflict"},     {31'd0, conflict}, 32'd0);
        chk({tag, "_conflict_idx"}, 32'(conflict_index), 32'd0);
        chk({tag, "_unit_count"},   32'(unit_count), 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0;
        cnf_packed = '0; clause_active = '0; lit_open = '0;
        clear_bank();
        drive_inputs();
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;

        // All clauses active with two open literals: no units, full-length scan.
        clear_bank();
        for (int c = 0; c < NC; c++) begin act[c] = 1'b1; opn[c] = 3'b011; end
        ready_mode = 0;
        run_scan(1'b1);

        // Unit at clause 5 stalled by ready, then a second unit at 9 after resume.
        clear_bank();
        act[5] = 1'b1; opn[5] = 3'b010; lits[5][1] = 9'h0A3;
        act[9] = 1'b1; opn[9] = 3'b001;
        ready_mode = 2;
        fork
            run_scan(1'b0);
            begin
                for (int i = 0; i < 100 && !ub.unit_valid; i++) @(negedge clk);
                repeat (4) begin
                    @(negedge clk);
                    chk("stall_valid", {31'd0, ub.unit_valid}, 32'd1);
                    chk("stall_literal", 32'(ub.unit_literal), 32'h0A3);
                    chk("stall_index", 32'(ub.unit_index), 32'd5);
                end
                ready_mode = 0;
            end
        join

        // Unit at 3, conflict at 7; unit at 10 must not be reached.
        clear_bank();
        act[3] = 1'b1; opn[3] = 3'b100;
        act[7] = 1'b1; opn[7] = 3'b000;
        act[10] = 1'b1; opn[10] = 3'b001;
        run_scan(1'b1);

        // Last-index boundary: inactive then active unit at clause 15.
        clear_bank();
        act[15] = 1'b0; opn[15] = 3'b001;
        run_scan(1'b1);
        act[15] = 1'b1;
        run_scan(1'b1);

        // Five units saturate the 2-bit counter; stray starts in SCAN and DONE are ignored.
        clear_bank();
        act[1] = 1'b1;  opn[1] = 3'b001;
        act[4] = 1'b1;  opn[4] = 3'b010;
        act[8] = 1'b1;  opn[8] = 3'b100;
        act[11] = 1'b1; opn[11] = 3'b010;
        act[14] = 1'b1; opn[14] = 3'b001;
        fork
            run_scan(1'b1);
            begin
                repeat (3) @(negedge clk);
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                for (int i = 0; i < 200 && !done; i++) @(negedge clk);
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
        join
        repeat (3) begin
            @(negedge clk);
            chk("start_in_done_ignored", {31'd0, busy}, 32'd0);
        end

        // Randomized scans, ready tied high or randomly stalled.
        for (int t = 0; t < 30; t++) begin
            gen_random(30, 3);
            ready_mode = (t % 2);
            run_scan(ready_mode == 0);
        end
        ready_mode = 0;

        // Reset while a unit is held, then a clean rescan from clause 0.
        clear_bank();
        act[5] = 1'b1; opn[5] = 3'b010; lits[5][1] = 9'h0A3;
        drive_inputs();
        ready_mode = 2;
        begin
            int lat_unused;
            model_and_push(lat_unused);
        end
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 100 && !ub.unit_valid; i++) @(negedge clk);
        chk("hold_before_reset", {31'd0, ub.unit_valid}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero("reset_in_hold");
        unit_q.delete(); res_q.delete();
        @(negedge clk);
        rst = 1'b0;
        ready_mode = 0;
        run_scan(1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
